ram_param: RTL and testbench

- Parametrised single-port synchronous RAM with a shared bidirectional data bus and chip-select/read/write strobes.
- Successor to the fixed 1Kx8 RAM: width, depth and read latency are parameters.
- Adds a pipelined read path with a valid flag and an optional post-reset memory-clear sequencer.
- Sits as a local storage block on the system data bus; the bus master owns `data` except while `rd_valid` is high.

---
 rtl/ram_param.sv | 221 ++++++++++++++++++++++
 tb/tb_ram_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_param
// Purpose  : Parametrised single-port synchronous RAM on a shared,
//            bidirectional data bus with chip-select / read / write strobes.
//            Reads are pipelined (RD_LAT = 1 or 2) and flagged by rd_valid.
//            Optional post-reset memory clear, enabled by defining the macro
//            RAM_PARAM_CLEAR_ON_RESET_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W    address width, depth = 2**ADDR_W words
//   DATA_W    word width
//   RD_LAT    read latency in cycles, 1 or 2 (other values stop elaboration)
//   CLEAR_VAL word written to every location by the clear sequencer
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   cs        chip select; rd/wr ignored while low
//   rd        read request
//   wr        write request (wins over rd when both are high)
//   addr      word address
//   data      bidirectional data bus; driven by the RAM only while rd_valid
//             is high and the master is not writing in the same cycle
//   rd_valid  read data is presented on data
//   busy      clear sequencer running; all accesses ignored
// ============================================================================
module ram_param #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned c_DEPTH = 2**ADDR_W;

  generate
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
      $fatal(1, "ram_param: RD_LAT must be 1 or 2");
    end
  endgenerate

  // Storage array; never reset, only written.
  logic [DATA_W-1:0] mem [c_DEPTH];

  logic              w_ready;      // accesses accepted
  logic              w_clear;      // clear sequencer writing this cycle
  logic [ADDR_W-1:0] w_clear_addr;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rd_acc;     // read accepted at the coming edge
  logic [DATA_W-1:0] w_rdata;
  logic              w_oe;

  // Final pipeline stage, shared by both latency variants.
  logic              valid_q;
  logic [DATA_W-1:0] dout_q;

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
`ifdef RAM_PARAM_CLEAR_ON_RESET_EN
  localparam logic [ADDR_W-1:0] c_CNT_LAST = '1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        // Last location is written on the same edge that leaves CLEAR,
        // so busy spans exactly 2**ADDR_W cycles.
        if (cnt_q == c_CNT_LAST) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  assign w_ready      = (state_q == ST_READY);
  assign w_clear      = (state_q == ST_CLEAR);
  assign w_clear_addr = cnt_q;
`else
  assign w_ready      = 1'b1;
  assign w_clear      = 1'b0;
  assign w_clear_addr = '0;
`endif

  assign busy = ~w_ready;

  // --------------------------------------------------------------------------
  // Write port: clear sequencer has priority, bus writes only when ready
  // --------------------------------------------------------------------------
  always_comb begin
    w_we    = 1'b0;
    w_waddr = addr;
    w_wdata = data;
    if (w_clear) begin
      w_we    = 1'b1;
      w_waddr = w_clear_addr;
      w_wdata = CLEAR_VAL;
    end else if (w_ready && cs && wr) begin
      w_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[w_waddr] <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline
  // --------------------------------------------------------------------------
  // A simultaneous write suppresses the read entirely.
  assign w_rd_acc = w_ready & cs & rd & ~wr;
  assign w_rdata  = mem[addr];

  generate
    if (RD_LAT == 1) begin : g_lat1
      logic              valid_d;
      logic [DATA_W-1:0] dout_d;

      always_comb begin
        valid_d = w_rd_acc;
        dout_d  = dout_q;
        if (w_rd_acc) begin
          dout_d = w_rdata;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          dout_q  <= '0;
        end else begin
          valid_q <= valid_d;
          dout_q  <= dout_d;
        end
      end
    end else begin : g_lat2
      logic              s1_valid_q, s1_valid_d;
      logic [DATA_W-1:0] s1_data_q, s1_data_d;
      logic              valid_d;
      logic [DATA_W-1:0] dout_d;

      always_comb begin
        s1_valid_d = w_rd_acc;
        s1_data_d  = s1_data_q;
        if (w_rd_acc) begin
          s1_data_d = w_rdata;
        end
        valid_d = s1_valid_q;
        dout_d  = dout_q;
        if (s1_valid_q) begin
          dout_d = s1_data_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
          valid_q    <= 1'b0;
          dout_q     <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_data_q  <= s1_data_d;
          valid_q    <= valid_d;
          dout_q     <= dout_d;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bus drive: combinational release whenever the master writes, so a read
  // slot that lands on a write cycle pulses rd_valid but never contends.
  // --------------------------------------------------------------------------
  assign w_oe     = valid_q & ~(cs & wr);
  assign rd_valid = valid_q;
  assign data     = w_oe ? dout_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_param
// Purpose  : Self-checking bench for ram_param. Two instances:
//            A: ADDR_W=4,  DATA_W=8,  RD_LAT=1, CLEAR_VAL=8'h5A
//            B: ADDR_W=10, DATA_W=16, RD_LAT=2, CLEAR_VAL=16'hC3C3
//            Expected read results are queued when a read is driven and
//            compared when the instance presents read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_param;

  localparam int LAT_A = 1;
  localparam int LAT_B = 2;
`ifdef RAM_PARAM_CLEAR_ON_RESET_EN
  localparam logic CLR_EN = 1'b1;
`else
  localparam logic CLR_EN = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [15:0] d;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic       cs_a, rd_a, wr_a, rd_valid_a, busy_a;
  logic [3:0] addr_a;
  logic [7:0] drv_a;
  wire  [7:0] data_a;
  assign data_a = (cs_a && wr_a) ? drv_a : 8'hzz;

  // Instance B signals
  logic        cs_b, rd_b, wr_b, rd_valid_b, busy_b;
  logic [9:0]  addr_b;
  logic [15:0] drv_b;
  wire  [15:0] data_b;
  assign data_b = (cs_b && wr_b) ? drv_b : 16'hzzzz;

  ram_param #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .CLEAR_VAL(8'h5A)) dut_a (
    .clk(clk), .rst(rst), .cs(cs_a), .rd(rd_a), .wr(wr_a), .addr(addr_a),
    .data(data_a), .rd_valid(rd_valid_a), .busy(busy_a)
  );

  ram_param #(.ADDR_W(10), .DATA_W(16), .RD_LAT(2), .CLEAR_VAL(16'hC3C3)) dut_b (
    .clk(clk), .rst(rst), .cs(cs_b), .rd(rd_b), .wr(wr_b), .addr(addr_b),
    .data(data_b), .rd_valid(rd_valid_b), .busy(busy_b)
  );

  // Reference models and scoreboards
  logic [7:0]  mem_a [16];
  logic        wrote_a [16];
  logic [15:0] mem_b [1024];
  sb_t         qa[$];
  sb_t         qb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic op_a(input logic c, input logic r, input logic w,
                      input logic [3:0] ad, input logic [7:0] d);
    @(posedge clk);
    #2;
    cs_a = c; rd_a = r; wr_a = w; addr_a = ad; drv_a = d;
    if (c && w) begin
      mem_a[ad]   = d;
      wrote_a[ad] = 1'b1;
    end else if (c && r) begin
      qa.push_back('{cyc + LAT_A, {8'h00, mem_a[ad]}});
    end
  endtask

  task automatic op_b(input logic c, input logic r, input logic w,
                      input logic [9:0] ad, input logic [15:0] d);
    @(posedge clk);
    #2;
    cs_b = c; rd_b = r; wr_b = w; addr_b = ad; drv_b = d;
    if (c && w) begin
      mem_b[ad] = d;
    end else if (c && r) begin
      qb.push_back('{cyc + LAT_B, mem_b[ad]});
    end
  endtask

  // Monitors: rd_valid must be high exactly when the oldest expected read
  // is due; the bus must be driven unless the master is writing.
  always @(negedge clk) begin : mon_a
    sb_t  it;
    logic ev;
    logic eo;
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    check_eq("a_rd_valid", 32'(rd_valid_a), 32'(ev));
    if (ev) begin
      it = qa.pop_front();
      eo = !(cs_a && wr_a);
      check_eq("a_drive", 32'(dut_a.w_oe), 32'(eo));
      if (eo) check_eq("a_data", 32'(data_a), 32'(it.d));
    end
  end

  always @(negedge clk) begin : mon_b
    sb_t  it;
    logic ev;
    logic eo;
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    check_eq("b_rd_valid", 32'(rd_valid_b), 32'(ev));
    if (ev) begin
      it = qb.pop_front();
      eo = !(cs_b && wr_b);
      check_eq("b_drive", 32'(dut_b.w_oe), 32'(eo));
      if (eo) check_eq("b_data", 32'(data_b), 32'(it.d));
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [3:0] ad;
    rst = 1'b1;
    cs_a = 0; rd_a = 0; wr_a = 0; addr_a = '0; drv_a = '0;
    cs_b = 0; rd_b = 0; wr_b = 0; addr_b = '0; drv_b = '0;
    for (int i = 0; i < 16; i++) wrote_a[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid_a", 32'(rd_valid_a), 32'(0));
    check_eq("rst_valid_b", 32'(rd_valid_b), 32'(0));
    check_eq("rst_drive_a", 32'(dut_a.w_oe), 32'(0));
    check_eq("rst_busy_a", 32'(busy_a), 32'(CLR_EN));
    check_eq("rst_busy_b", 32'(busy_b), 32'(CLR_EN));

    @(posedge clk);
    #2;
    rst = 1'b0;

`ifdef RAM_PARAM_CLEAR_ON_RESET_EN
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          check_eq("clear_busy_a", 32'(busy_a), 32'(1));
        end
        @(negedge clk);
        check_eq("clear_done_a", 32'(busy_a), 32'(0));
      end
      begin
        // Write attempt late in the clear, after addr 3 was already cleared.
        repeat (9) @(posedge clk);
        #2;
        cs_a = 1; wr_a = 1; addr_a = 4'd3; drv_a = 8'hFF;
        repeat (6) @(posedge clk);
        #2;
        cs_a = 0; wr_a = 0;
      end
    join
    for (int i = 0; i < 16; i++) begin
      mem_a[i]   = 8'h5A;
      wrote_a[i] = 1'b1;
    end
    for (int i = 0; i < 1024; i++) mem_b[i] = 16'hC3C3;
    op_a(1, 1, 0, 4'd3, 8'h00);           // expect 8'h5A, not 8'hFF
`else
    @(negedge clk);
    check_eq("busy_a_off", 32'(busy_a), 32'(0));
    check_eq("busy_b_off", 32'(busy_b), 32'(0));
`endif

    // Basic write / back-to-back reads
    op_a(1, 0, 1, 4'd5, 8'hAA);
    op_a(1, 0, 1, 4'd10, 8'h55);
    op_a(1, 1, 0, 4'd5, 8'h00);
    op_a(1, 1, 0, 4'd10, 8'h00);
    op_a(0, 0, 0, 4'd0, 8'h00);
    op_a(0, 0, 0, 4'd0, 8'h00);

    // rd and wr together: write wins, no read slot
    op_a(1, 1, 1, 4'd7, 8'h33);
    op_a(1, 1, 0, 4'd7, 8'h00);
    op_a(0, 0, 0, 4'd0, 8'h00);

    // cs low: no write, no read
    op_a(0, 0, 1, 4'd5, 8'hEE);
    op_a(0, 1, 0, 4'd5, 8'h00);
    op_a(1, 1, 0, 4'd5, 8'h00);
    // Read-after-write on consecutive edges, then read slot hit by a write
    op_a(1, 0, 1, 4'd9, 8'h77);
    op_a(1, 1, 0, 4'd9, 8'h00);
    op_a(1, 0, 1, 4'd12, 8'h12);
    op_a(1, 1, 0, 4'd12, 8'h00);
    op_a(0, 0, 0, 4'd0, 8'h00);

    // Mixed random traffic, only reading locations with a known value
    for (int i = 0; i < 32; i++) begin
      ad = 4'($urandom_range(0, 15));
      if (!wrote_a[ad] || ($urandom_range(0, 2) == 0))
        op_a(1, 0, 1, ad, 8'($urandom));
      else
        op_a(1, 1, 0, ad, 8'h00);
    end
    op_a(0, 0, 0, 4'd0, 8'h00);
    op_a(0, 0, 0, 4'd0, 8'h00);

    // Instance B: wait for its clear (bounded)
    n = 0;
    while ((busy_b !== 1'b0) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check_eq("b_ready", 32'(busy_b), 32'(0));

    op_b(1, 0, 1, 10'h3FF, 16'hBEEF);
    op_b(1, 1, 0, 10'h3FF, 16'h0000);
    op_b(0, 0, 0, 10'h000, 16'h0000);
    op_b(0, 0, 0, 10'h000, 16'h0000);
    op_b(0, 0, 0, 10'h000, 16'h0000);
    // Read then write next edge (no overlap), and read then write in the
    // valid cycle (bus released, rd_valid still pulses)
    op_b(1, 0, 1, 10'd5, 16'h00AA);
    op_b(1, 1, 0, 10'd5, 16'h0000);
    op_b(1, 0, 1, 10'd6, 16'h0011);
    op_b(1, 1, 0, 10'd5, 16'h0000);
    op_b(0, 0, 0, 10'd0, 16'h0000);
    op_b(1, 0, 1, 10'd7, 16'h1234);
    op_b(0, 0, 0, 10'd0, 16'h0000);
    // Pipelined reads
    op_b(1, 1, 0, 10'd6, 16'h0000);
    op_b(1, 1, 0, 10'h3FF, 16'h0000);
    op_b(1, 1, 0, 10'd7, 16'h0000);
    op_b(1, 1, 1, 10'd8, 16'h4321);
    op_b(1, 1, 0, 10'd8, 16'h0000);
    repeat (4) op_b(0, 0, 0, 10'd0, 16'h0000);
    op_a(0, 0, 0, 4'd0, 8'h00);

    check_eq("a_queue_empty", 32'(qa.size()), 32'(0));
    check_eq("b_queue_empty", 32'(qb.size()), 32'(0));

    // Reset while read data is on the bus
    op_a(1, 1, 0, 4'd5, 8'h00);
    @(posedge clk);
    #1;
    check_eq("midrst_valid_pre", 32'(rd_valid_a), 32'(1));
    cs_a = 0; rd_a = 0;
    #1;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    check_eq("midrst_valid", 32'(rd_valid_a), 32'(0));
    check_eq("midrst_drive", 32'(dut_a.w_oe), 32'(0));
    check_eq("midrst_busy", 32'(busy_a), 32'(CLR_EN));
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(busy_a), 32'(CLR_EN));
    check_eq("post_rst_valid", 32'(rd_valid_a), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
